// File: rtl/univ_reg_if.sv
// Bus bundle for univ_reg: operation controls in, register contents and status out.
interface univ_reg_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout_l;
  logic             sout_r;
  logic             zero;
  logic             changed;

  modport master (
    output en, mode, d, sin_l, sin_r,
    input  q, qbar, sout_l, sout_r, zero, changed
  );

  modport slave (
    input  en, mode, d, sin_l, sin_r,
    output q, qbar, sout_l, sout_r, zero, changed
  );
endinterface

// File: rtl/univ_reg.sv
// Universal register: hold/load/shift/rotate/toggle/clear of a WIDTH-bit word,
// with complementary output, serial taps, zero flag and registered change flag.
module univ_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic      clk,
  input logic      rst,
  univ_reg_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_TOG  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  mode_e            op;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] sl_word;
  logic [WIDTH-1:0] sr_word;
  logic             changed_r;

  assign op = mode_e'(bus.mode);

  // Serial inputs placed at their entry bit positions
  always_comb begin
    sl_word             = '0;
    sr_word             = '0;
    sl_word[0]          = bus.sin_l;
    sr_word[WIDTH-1]    = bus.sin_r;
  end

  // Next-state selection; shifts are built from shift/OR rather than part-selects
  // so WIDTH=1 degenerates naturally (shifts take the serial bit, rotates hold)
  always_comb begin
    next_q = q_r;
    if (bus.en) begin
      case (op)
        MODE_HOLD: next_q = q_r;
        MODE_LOAD: next_q = bus.d;
        MODE_SHL:  next_q = (q_r << 1) | sl_word;
        MODE_SHR:  next_q = (q_r >> 1) | sr_word;
        MODE_ROL:  next_q = (q_r << 1) | (q_r >> (WIDTH - 1));
        MODE_ROR:  next_q = (q_r >> 1) | (q_r << (WIDTH - 1));
        MODE_TOG:  next_q = ~q_r;
        MODE_CLR:  next_q = '0;
        default:   next_q = q_r;
      endcase
    end
  end

  // Register update and change detection; reset dominates enable and mode
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r       <= RESET_VAL;
      changed_r <= 1'b0;
    end else begin
      q_r       <= next_q;
      changed_r <= (next_q != q_r);
    end
  end

  assign bus.q       = q_r;
  assign bus.qbar    = ~q_r;
  assign bus.sout_l  = q_r[WIDTH-1];
  assign bus.sout_r  = q_r[0];
  assign bus.zero    = (q_r == '0);
  assign bus.changed = changed_r;

endmodule

// File: tb/tb_univ_reg.sv
// Directed + short random bench for univ_reg at WIDTH=8 (RESET_VAL=A5) and WIDTH=1.
module tb_univ_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  univ_reg_if #(.WIDTH(8)) bus8 ();
  univ_reg_if #(.WIDTH(1)) bus1 ();

  univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  univ_reg #(.WIDTH(1), .RESET_VAL(1'b0))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // stimulus variables
  logic       en8 = 1'b1, sl8 = 1'b0, sr8 = 1'b0;
  logic [2:0] md8 = 3'b001;
  logic [7:0] d8  = 8'hFF;
  logic       en1 = 1'b0, d1 = 1'b0, sl1 = 1'b0, sr1 = 1'b0;
  logic [2:0] md1 = 3'b000;

  // reference model state
  logic [7:0] mq8;
  logic       mc8;
  logic       mq1;
  logic       mc1;

  function automatic logic [7:0] model8(logic [7:0] q, logic [2:0] m, logic [7:0] d,
                                        logic sl, logic sr);
    case (m)
      3'd1:    return d;
      3'd2:    return {q[6:0], sl};
      3'd3:    return {sr, q[7:1]};
      3'd4:    return {q[6:0], q[7]};
      3'd5:    return {q[0], q[7:1]};
      3'd6:    return ~q;
      3'd7:    return 8'h00;
      default: return q;
    endcase
  endfunction

  function automatic logic model1(logic q, logic [2:0] m, logic d, logic sl, logic sr);
    case (m)
      3'd1:    return d;
      3'd2:    return sl;
      3'd3:    return sr;
      3'd6:    return ~q;
      3'd7:    return 1'b0;
      default: return q;
    endcase
  endfunction

  function automatic logic [7:0] observe(int sel);
    case (sel)
      0:       return bus8.q;
      1:       return bus8.qbar;
      2:       return {7'b0, bus8.zero};
      3:       return {7'b0, bus8.sout_l};
      4:       return {7'b0, bus8.sout_r};
      5:       return {7'b0, bus8.changed};
      10:      return {7'b0, bus1.q};
      11:      return {7'b0, bus1.qbar};
      12:      return {7'b0, bus1.zero};
      13:      return {7'b0, bus1.sout_l};
      14:      return {7'b0, bus1.sout_r};
      default: return {7'b0, bus1.changed};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [7:0] v);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = v;
    sb.push_back(it);
  endtask

  task automatic drain();
    sb_item_t   it;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.sel);
      n_cmp++;
      assert (obs === it.exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  // Drive inputs, advance the model one edge, queue model expectations, then compare
  task automatic tick();
    logic [7:0] n8;
    logic       n1;
    bus8.en = en8; bus8.mode = md8; bus8.d = d8; bus8.sin_l = sl8; bus8.sin_r = sr8;
    bus1.en = en1; bus1.mode = md1; bus1.d = d1; bus1.sin_l = sl1; bus1.sin_r = sr1;
    if (rst) begin
      mq8 = 8'hA5; mc8 = 1'b0;
      mq1 = 1'b0;  mc1 = 1'b0;
    end else begin
      n8  = en8 ? model8(mq8, md8, d8, sl8, sr8) : mq8;
      mc8 = (n8 != mq8);
      mq8 = n8;
      n1  = en1 ? model1(mq1, md1, d1, sl1, sr1) : mq1;
      mc1 = (n1 != mq1);
      mq1 = n1;
    end
    expect_val("m8_q", 0, mq8);
    expect_val("m8_qbar", 1, ~mq8);
    expect_val("m8_zero", 2, {7'b0, mq8 == 8'h00});
    expect_val("m8_sout_l", 3, {7'b0, mq8[7]});
    expect_val("m8_sout_r", 4, {7'b0, mq8[0]});
    expect_val("m8_changed", 5, {7'b0, mc8});
    expect_val("m1_q", 10, {7'b0, mq1});
    expect_val("m1_qbar", 11, {7'b0, ~mq1});
    expect_val("m1_zero", 12, {7'b0, ~mq1});
    expect_val("m1_sout_l", 13, {7'b0, mq1});
    expect_val("m1_sout_r", 14, {7'b0, mq1});
    expect_val("m1_changed", 15, {7'b0, mc1});
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    // 1. reset held two edges with load request pending
    rst = 1'b1; en8 = 1'b1; md8 = 3'b001; d8 = 8'hFF;
    tick();
    expect_val("rst_q", 0, 8'hA5);
    expect_val("rst_qbar", 1, 8'h5A);
    expect_val("rst_changed", 5, 8'h00);
    expect_val("rst_zero", 2, 8'h00);
    expect_val("rst_w1_q", 10, 8'h00);
    expect_val("rst_w1_zero", 12, 8'h01);
    tick();

    // 2. load, hold, disabled toggle
    rst = 1'b0; md8 = 3'b001; d8 = 8'h3C;
    expect_val("load_q", 0, 8'h3C);
    expect_val("load_changed", 5, 8'h01);
    tick();
    md8 = 3'b000;
    expect_val("hold_changed", 5, 8'h00);
    tick();
    en8 = 1'b0; md8 = 3'b110;
    expect_val("en0_q", 0, 8'h3C);
    expect_val("en0_changed", 5, 8'h00);
    tick();
    en8 = 1'b1; md8 = 3'b001; d8 = 8'h3C;
    expect_val("load_same_changed", 5, 8'h00);
    tick();

    // 3. shift chain
    d8 = 8'h81; tick();
    md8 = 3'b010; sl8 = 1'b0;
    expect_val("shl_q", 0, 8'h02);
    expect_val("shl_sout_l", 3, 8'h00);
    tick();
    md8 = 3'b011; sr8 = 1'b1;
    expect_val("shr_q", 0, 8'h81);
    expect_val("shr_sout_r", 4, 8'h01);
    tick();
    md8 = 3'b010; sl8 = 1'b1;
    expect_val("shl1_q", 0, 8'h03);
    tick();
    md8 = 3'b011; sr8 = 1'b0;
    expect_val("shr0_q", 0, 8'h01);
    tick();

    // 4. rotate
    md8 = 3'b001; d8 = 8'h81; tick();
    md8 = 3'b100;
    expect_val("rol_q", 0, 8'h03);
    tick();
    md8 = 3'b101;
    expect_val("ror_q", 0, 8'h81);
    tick();
    md8 = 3'b001; d8 = 8'hFF; tick();
    md8 = 3'b100;
    expect_val("rol_ff_q", 0, 8'hFF);
    expect_val("rol_ff_changed", 5, 8'h00);
    tick();

    // 5. toggle and clear
    md8 = 3'b001; d8 = 8'h0F; tick();
    md8 = 3'b110;
    expect_val("tog_q", 0, 8'hF0);
    expect_val("tog_qbar", 1, 8'h0F);
    tick();
    md8 = 3'b111;
    expect_val("clr_q", 0, 8'h00);
    expect_val("clr_zero", 2, 8'h01);
    expect_val("clr_changed", 5, 8'h01);
    tick();
    expect_val("clr2_changed", 5, 8'h00);
    tick();

    // 6. reset priority, then WIDTH=1 corners
    rst = 1'b1; md8 = 3'b001; d8 = 8'h77;
    expect_val("rstpri_q", 0, 8'hA5);
    expect_val("rstpri_changed", 5, 8'h00);
    tick();
    rst = 1'b0; en8 = 1'b0;
    en1 = 1'b1; md1 = 3'b010; sl1 = 1'b1;
    expect_val("w1_shl_q", 10, 8'h01);
    expect_val("w1_shl_changed", 15, 8'h01);
    tick();
    md1 = 3'b100;
    expect_val("w1_rol_q", 10, 8'h01);
    expect_val("w1_rol_changed", 15, 8'h00);
    tick();
    md1 = 3'b101;
    expect_val("w1_ror_q", 10, 8'h01);
    expect_val("w1_ror_changed", 15, 8'h00);
    tick();
    md1 = 3'b011; sr1 = 1'b0;
    expect_val("w1_shr_q", 10, 8'h00);
    tick();
    md1 = 3'b110;
    expect_val("w1_tog_q", 10, 8'h01);
    expect_val("w1_tog_sout_l", 13, 8'h01);
    tick();

    // Random operations on both widths against the model
    for (int i = 0; i < 40; i++) begin
      en8 = ($urandom_range(0, 3) != 0);
      md8 = 3'($urandom_range(0, 7));
      d8  = 8'($urandom_range(0, 255));
      sl8 = 1'($urandom_range(0, 1));
      sr8 = 1'($urandom_range(0, 1));
      en1 = ($urandom_range(0, 3) != 0);
      md1 = 3'($urandom_range(0, 7));
      d1  = 1'($urandom_range(0, 1));
      sl1 = 1'($urandom_range(0, 1));
      sr1 = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
